// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle controller: state codes, opcode codes,
// PC-source / ALU-B-source / ALU-op encodings, default parameter widths, the
// control-strobe bundle passed from the output decoder to the top level, and
// a helper that identifies the edges on which an instruction retires.
// -----------------------------------------------------------------------------
package mc_pkg;

   // Default parameter values for multicycle_ctrl
   localparam int OP_W_DEF   = 4;
   localparam int DATA_W_DEF = 16;
   localparam int CNT_W_DEF  = 16;

   // Controller state codes (visible on the cs port)
   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JUMP   = 4'd11,
      ST_TRAP   = 4'd12
   } state_e;

   // Opcode codes; any other value is an illegal instruction
   localparam int OP_R    = 0;
   localparam int OP_LW   = 1;
   localparam int OP_SW   = 2;
   localparam int OP_BEQ  = 3;
   localparam int OP_ADDI = 4;
   localparam int OP_J    = 5;

   // PC source select
   localparam logic [1:0] PCSIG_ALU    = 2'd0;
   localparam logic [1:0] PCSIG_ALUOUT = 2'd1;
   localparam logic [1:0] PCSIG_JUMP   = 2'd2;
   localparam logic [1:0] PCSIG_TRAP   = 2'd3;

   // ALU B-operand source select
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BRIMM = 2'b11;

   // ALU operation select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Control strobes produced by the Moore output decoder
   typedef struct packed {
      logic [1:0] pcsig;
      logic       pcwrite;
      logic       id;
      logic       instwr;
      logic       mem_req;
      logic       memwrite;
      logic       load;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       trap;
      logic       branch;
   } ctrl_t;

   // True when the current state hands a completed instruction back to FETCH
   // on the next edge. MEMWR only leaves once memory accepts the write; a
   // trap never counts as a completed instruction.
   function automatic logic retires(input state_e st, input logic rdy);
      logic r;
      case (st)
         ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: r = 1'b1;
         ST_MEMWR:                                          r = rdy;
         default:                                           r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Combinational Moore output decoder: maps the controller state (plus the
// memory-ready handshake, which qualifies the FETCH write strobes) onto the
// datapath control strobes. Every strobe not named for a state is 0.
//
// Ports
//   state_i   : current controller state
//   mem_rdy_i : memory access completes this cycle (already WAIT_EN-qualified)
//   ctrl_o    : control strobe bundle, including the internal branch term
// -----------------------------------------------------------------------------
module mc_decode
   import mc_pkg::*;
(
   input  state_e state_i,
   input  logic   mem_rdy_i,
   output ctrl_t  ctrl_o
);

   // State-to-strobe table; all fields default to 0 before the per-state overrides
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.alusrca = 1'b0;
            ctrl_o.alusrcb = SRCB_FOUR;
            ctrl_o.aluop   = ALUOP_ADD;
            ctrl_o.pcsig   = PCSIG_ALU;
            // IR and PC are only loaded on the cycle the fetch completes
            if (mem_rdy_i) begin
               ctrl_o.instwr  = 1'b1;
               ctrl_o.pcwrite = 1'b1;
            end else begin
               ctrl_o.instwr  = 1'b0;
               ctrl_o.pcwrite = 1'b0;
            end
         end
         ST_DECODE: begin
            ctrl_o.alusrca = 1'b0;
            ctrl_o.alusrcb = SRCB_BRIMM;
            ctrl_o.aluop   = ALUOP_ADD;
         end
         ST_MEMADR, ST_ADDIEX: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_ADD;
         end
         ST_MEMRD: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.id      = 1'b1;
         end
         ST_MEMWB: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.load     = 1'b1;
            ctrl_o.regdst   = 1'b0;
         end
         ST_MEMWR: begin
            ctrl_o.mem_req  = 1'b1;
            ctrl_o.id       = 1'b1;
            ctrl_o.memwrite = 1'b1;
         end
         ST_EXEC: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_REG;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         ST_ALUWB: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
         end
         ST_BRANCH: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_REG;
            ctrl_o.aluop   = ALUOP_SUB;
            ctrl_o.pcsig   = PCSIG_ALUOUT;
            ctrl_o.branch  = 1'b1;
         end
         ST_ADDIWB: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b0;
         end
         ST_JUMP: begin
            ctrl_o.pcwrite = 1'b1;
            ctrl_o.pcsig   = PCSIG_JUMP;
         end
         ST_TRAP: begin
            ctrl_o.pcwrite = 1'b1;
            ctrl_o.pcsig   = PCSIG_TRAP;
            ctrl_o.trap    = 1'b1;
         end
         default: begin
            ctrl_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore-FSM controller for a multicycle processor datapath. Sequences
// FETCH/DECODE and the per-opcode execute states, stalls on memory handshakes,
// traps on illegal opcodes and counts retired instructions.
//
// Ports
//   cl       : clock, rising edge
//   nrst     : asynchronous active-low reset
//   instr    : instruction register contents (opcode in the top OP_W bits)
//   zero     : ALU zero flag (branch condition)
//   mem_rdy  : memory access completes this cycle
//   cs       : current state code
//   pcsig .. trap : datapath control strobes
//   retired  : count of completed instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int   OP_W    = OP_W_DEF,
   parameter int   DATA_W  = DATA_W_DEF,
   parameter int   CNT_W   = CNT_W_DEF,
   parameter logic WAIT_EN = 1'b1
) (
   input  logic              cl,
   input  logic              nrst,
   input  logic [DATA_W-1:0] instr,
   input  logic              zero,
   input  logic              mem_rdy,
   output logic [3:0]        cs,
   output logic [1:0]        pcsig,
   output logic              pcwrite,
   output logic              pcen,
   output logic              id,
   output logic              instwr,
   output logic              mem_req,
   output logic              memwrite,
   output logic              load,
   output logic              regdst,
   output logic              regwrite,
   output logic              alusrca,
   output logic [1:0]        alusrcb,
   output logic [1:0]        aluop,
   output logic              trap,
   output logic [CNT_W-1:0]  retired
);

   state_e             state_q;
   state_e             state_d;
   logic [CNT_W-1:0]   retired_q;
   logic [CNT_W-1:0]   retired_d;
   logic               rdy_s;
   logic [OP_W-1:0]    opcode_s;
   ctrl_t              ctrl_s;
   logic               unused_s;

   // With WAIT_EN=0 every memory access completes in one cycle
   assign rdy_s    = WAIT_EN ? mem_rdy : 1'b1;
   assign opcode_s = instr[DATA_W-1 -: OP_W];
   // Operand fields of the instruction are datapath concerns, not control
   assign unused_s = ^instr[DATA_W-OP_W-1:0];

   // Next-state logic; instr is only consulted in DECODE and MEMADR
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (rdy_s) begin
               state_d = ST_DECODE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            case (opcode_s)
               OP_W'(OP_R):    state_d = ST_EXEC;
               OP_W'(OP_LW):   state_d = ST_MEMADR;
               OP_W'(OP_SW):   state_d = ST_MEMADR;
               OP_W'(OP_BEQ):  state_d = ST_BRANCH;
               OP_W'(OP_ADDI): state_d = ST_ADDIEX;
               OP_W'(OP_J):    state_d = ST_JUMP;
               default:        state_d = ST_TRAP;
            endcase
         end
         ST_MEMADR: begin
            if (opcode_s == OP_W'(OP_SW)) begin
               state_d = ST_MEMWR;
            end else begin
               state_d = ST_MEMRD;
            end
         end
         ST_MEMRD: begin
            if (rdy_s) begin
               state_d = ST_MEMWB;
            end else begin
               state_d = ST_MEMRD;
            end
         end
         ST_MEMWR: begin
            if (rdy_s) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_MEMWR;
            end
         end
         ST_EXEC:   state_d = ST_ALUWB;
         ST_ADDIEX: state_d = ST_ADDIWB;
         ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP, ST_TRAP: begin
            state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Retire counter next value; natural overflow gives the modulo wrap
   always_comb begin
      retired_d = retired_q;
      if (retires(state_q, rdy_s)) begin
         retired_d = retired_q + CNT_W'(1);
      end else begin
         retired_d = retired_q;
      end
   end

   // State and retire-counter registers
   always_ff @(posedge cl or negedge nrst) begin
      if (!nrst) begin
         state_q   <= ST_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   mc_decode u_decode (
      .state_i   (state_q),
      .mem_rdy_i (rdy_s),
      .ctrl_o    (ctrl_s)
   );

   // Write/request strobes are gated by nrst so a reset, even mid-stall, kills
   // them immediately; the remaining selects show FETCH values since the state
   // register is already forced to FETCH.
   assign mem_req  = nrst & ctrl_s.mem_req;
   assign instwr   = nrst & ctrl_s.instwr;
   assign pcwrite  = nrst & ctrl_s.pcwrite;
   assign memwrite = nrst & ctrl_s.memwrite;
   assign regwrite = nrst & ctrl_s.regwrite;
   assign trap     = nrst & ctrl_s.trap;
   assign pcen     = nrst & (ctrl_s.pcwrite | (ctrl_s.branch & zero));

   assign pcsig    = ctrl_s.pcsig;
   assign id       = ctrl_s.id;
   assign load     = ctrl_s.load;
   assign regdst   = ctrl_s.regdst;
   assign alusrca  = ctrl_s.alusrca;
   assign alusrcb  = ctrl_s.alusrcb;
   assign aluop    = ctrl_s.aluop;

   assign cs       = state_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each instruction is expanded by the
// bench into the list of states it must visit (with chosen stall lengths), and
// every cycle the state code, all control strobes and the retire count are
// compared with values derived from the controller's behavioural description.
// A 4-bit retire counter is used so the wrap-around is exercised.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int TB_CNT_W = 4;

   logic                cl   = 1'b0;
   logic                nrst = 1'b1;
   logic [15:0]         instr = 16'h0000;
   logic                zero = 1'b0;
   logic                mem_rdy = 1'b1;
   logic [3:0]          cs;
   logic [1:0]          pcsig;
   logic                pcwrite, pcen, id, instwr, mem_req, memwrite;
   logic                load, regdst, regwrite, alusrca, trap;
   logic [1:0]          alusrcb, aluop;
   logic [TB_CNT_W-1:0] retired;
   logic [16:0]         obs_ctrl;

   int n_vec = 0;
   int n_bad = 0;
   int model_retired = 0;

   multicycle_ctrl #(
      .OP_W    (4),
      .DATA_W  (16),
      .CNT_W   (TB_CNT_W),
      .WAIT_EN (1'b1)
   ) dut (
      .cl       (cl),
      .nrst     (nrst),
      .instr    (instr),
      .zero     (zero),
      .mem_rdy  (mem_rdy),
      .cs       (cs),
      .pcsig    (pcsig),
      .pcwrite  (pcwrite),
      .pcen     (pcen),
      .id       (id),
      .instwr   (instwr),
      .mem_req  (mem_req),
      .memwrite (memwrite),
      .load     (load),
      .regdst   (regdst),
      .regwrite (regwrite),
      .alusrca  (alusrca),
      .alusrcb  (alusrcb),
      .aluop    (aluop),
      .trap     (trap),
      .retired  (retired)
   );

   always #5 cl = ~cl;

   assign obs_ctrl = {pcsig, pcwrite, pcen, id, instwr, mem_req, memwrite,
                      load, regdst, regwrite, alusrca, alusrcb, aluop, trap};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Expected strobes for a state code, in the obs_ctrl packing order
   function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic z,
                                            input logic in_rst);
      logic [1:0] psig = 2'd0, srcb = 2'd0, aop = 2'd0;
      logic pw = 1'b0, pe = 1'b0, idv = 1'b0, iw = 1'b0, mr = 1'b0, mw = 1'b0;
      logic ld = 1'b0, rd = 1'b0, rw = 1'b0, sa = 1'b0, tr = 1'b0;
      if (in_rst) begin
         srcb = 2'b01;
      end else begin
         case (st)
            0:  begin mr = 1'b1; srcb = 2'b01; iw = rdy; pw = rdy; pe = rdy; end
            1:  srcb = 2'b11;
            2:  begin sa = 1'b1; srcb = 2'b10; end
            3:  begin mr = 1'b1; idv = 1'b1; end
            4:  begin rw = 1'b1; ld = 1'b1; end
            5:  begin mr = 1'b1; idv = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin sa = 1'b1; aop = 2'b01; psig = 2'd1; pe = z; end
            9:  begin sa = 1'b1; srcb = 2'b10; end
            10: rw = 1'b1;
            11: begin pw = 1'b1; pe = 1'b1; psig = 2'd2; end
            12: begin pw = 1'b1; pe = 1'b1; psig = 2'd3; tr = 1'b1; end
            default: psig = 2'd0;
         endcase
      end
      return {psig, pw, pe, idv, iw, mr, mw, ld, rd, rw, sa, srcb, aop, tr};
   endfunction

   // One clock cycle: drive inputs on the falling edge, check before the rising edge.
   // rdy_sel: 0 = not ready, 1 = ready, 2 = random (state must ignore it).
   task automatic step(input int st, input int rdy_sel, input logic [15:0] iv);
      logic r;
      logic z;
      @(negedge cl);
      if (rdy_sel == 2) r = 1'($urandom_range(0, 1));
      else              r = (rdy_sel == 1);
      z = 1'($urandom_range(0, 1));
      mem_rdy = r;
      zero    = z;
      instr   = iv;
      #2;
      check_eq("cs", 32'(cs), 32'(st));
      check_eq("ctrl", 32'(obs_ctrl), 32'(exp_ctrl(st, r, z, 1'b0)));
      check_eq("retired", 32'(retired), 32'(model_retired));
   endtask

   function automatic logic [15:0] junk();
      return 16'($urandom);
   endfunction

   // Execute one instruction through the controller; instr is junk outside
   // the cycles in which it must be honoured.
   task automatic run_instr(input logic [15:0] iw, input int fst, input int mst);
      logic [3:0] op;
      op = iw[15:12];
      for (int k = 0; k < fst; k++) step(0, 0, junk());
      step(0, 1, junk());
      step(1, 2, iw);
      case (op)
         4'd0: begin step(6, 2, junk()); step(7, 2, junk()); end
         4'd1: begin
            step(2, 2, iw);
            for (int k = 0; k < mst; k++) step(3, 0, junk());
            step(3, 1, junk());
            step(4, 2, junk());
         end
         4'd2: begin
            step(2, 2, iw);
            for (int k = 0; k < mst; k++) step(5, 0, junk());
            step(5, 1, junk());
         end
         4'd3: step(8, 2, junk());
         4'd4: begin step(9, 2, junk()); step(10, 2, junk()); end
         4'd5: step(11, 2, junk());
         default: step(12, 2, junk());
      endcase
      if (op <= 4'd5) model_retired = (model_retired + 1) % (1 << TB_CNT_W);
   endtask

   initial begin
      // Power-on reset; strobes must stay low even with mem_rdy high
      #1 nrst = 1'b0;
      #1;
      check_eq("rst_cs", 32'(cs), 32'd0);
      check_eq("rst_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(0, 1'b1, 1'b0, 1'b1)));
      check_eq("rst_retired", 32'(retired), 32'd0);
      repeat (2) @(posedge cl);
      @(negedge cl);
      mem_rdy = 1'b0;
      nrst    = 1'b1;

      // Directed instructions
      run_instr(16'h0123, 0, 0);   // R-type
      run_instr(16'h1abc, 1, 3);   // LW with three MEMRD wait states
      run_instr(16'h3000, 0, 0);   // BEQ
      run_instr(16'h3456, 0, 0);   // BEQ
      run_instr(16'hF000, 2, 0);   // illegal -> trap
      run_instr(16'h2123, 0, 2);   // SW with stalls
      run_instr(16'h5000, 0, 0);   // J
      run_instr(16'h4777, 1, 0);   // ADDI

      // Randomised instruction stream, about one in four illegal
      for (int n = 0; n < 250; n++) begin
         logic [3:0] op;
         if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(6, 15));
         else                           op = 4'($urandom_range(0, 5));
         run_instr({op, 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // Reset asserted during a MEMWR stall
      step(0, 1, junk());
      step(1, 2, 16'h2abc);
      step(2, 2, 16'h2abc);
      step(5, 0, junk());
      step(5, 0, junk());
      @(negedge cl);
      mem_rdy = 1'b0;
      #2;
      nrst = 1'b0;
      #1;
      model_retired = 0;
      check_eq("rst_wr_cs", 32'(cs), 32'd0);
      check_eq("rst_wr_memwrite", 32'(memwrite), 32'd0);
      check_eq("rst_wr_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0, 1'b1)));
      check_eq("rst_wr_retired", 32'(retired), 32'd0);
      mem_rdy = 1'b1;
      #1;
      check_eq("rst_rdy_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(0, 1'b1, 1'b0, 1'b1)));
      @(posedge cl);
      @(negedge cl);
      mem_rdy = 1'b0;
      nrst    = 1'b1;

      // Sixteen ADDIs bring the 4-bit retire count back to zero
      for (int n = 0; n < 16; n++) begin
         run_instr({4'd4, 12'($urandom)}, $urandom_range(0, 1), 0);
      end
      @(negedge cl);
      mem_rdy = 1'b0;
      #2;
      check_eq("wrap", 32'(retired), 32'd0);
      check_eq("wrap_cs", 32'(cs), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter OP_W, 4: opcode field width, taken from instr[DATA_W-1 -: OP_W].
REQ-002 SHALL have parameter DATA_W, 16: instruction width.
REQ-003 SHALL have parameter CNT_W, 16: retire-counter width.
REQ-004 SHALL have parameter WAIT_EN, 1: 1 = honour mem_rdy; 0 = treat mem_rdy as constant 1.
REQ-005 SHALL have port cl  input  1  clock, rising edge.
REQ-006 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port instr  input  DATA_W  instruction register contents.
REQ-008 SHALL have port zero  input  1  ALU zero flag.
REQ-009 SHALL have port mem_rdy  input  1  memory access completes this cycle.
REQ-010 SHALL have port cs  output  4  current state code.
REQ-011 SHALL have the following control ports, all outputs:
- pcsig  2  PC source: 0 ALU, 1 ALUOut, 2 jump, 3 trap vector.
- pcwrite  1
- pcen  1  PC enable.
- id  1  IorD address select.
- instwr  1  IR write.
- mem_req  1
- memwrite  1
- load  1  MemtoReg.
- regdst  1
- regwrite  1
- alusrca  1
- alusrcb  2
- aluop  2
- trap  1
REQ-012 SHALL have port retired  output  CNT_W  count of completed instructions.

Function
REQ-013 SHALL implement a Moore FSM with these state codes:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12
REQ-014 SHALL decode the opcode as: 0 R-type, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J; every other value is illegal.
REQ-015 SHALL apply these transitions:
- FETCH->DECODE.
- DECODE->MEMADR (LW/SW), EXEC (R), BRANCH (BEQ), ADDIEX (ADDI), JUMP (J), TRAP (illegal).
- MEMADR->MEMRD (LW) or MEMWR (SW).
- MEMRD->MEMWB.
- EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP, TRAP->FETCH.
REQ-016 SHALL, in FETCH, MEMRD and MEMWR, hold the state while mem_rdy=0 and leave only on the edge where mem_rdy=1.
REQ-017 SHALL assert mem_req in FETCH, MEMRD and MEMWR; id=1 in MEMRD and MEMWR; memwrite=1 for every cycle of MEMWR.
REQ-018 SHALL assert instwr and pcwrite in FETCH only in the cycle mem_rdy=1, with alusrca=0, alusrcb=01, aluop=00, pcsig=0.
REQ-019 SHALL drive DECODE with alusrca=0, alusrcb=11, aluop=00.
REQ-020 SHALL drive MEMADR and ADDIEX with alusrca=1, alusrcb=10, aluop=00.
REQ-021 SHALL drive EXEC with alusrca=1, alusrcb=00, aluop=10.
REQ-022 SHALL drive BRANCH with alusrca=1, alusrcb=00, aluop=01, pcsig=1, and set its branch term.
REQ-023 SHALL drive the write-back states as follows:
- MEMWB: regwrite=1, load=1, regdst=0.
- ALUWB: regwrite=1, regdst=1.
- ADDIWB: regwrite=1, regdst=0.
REQ-024 SHALL drive JUMP with pcwrite=1, pcsig=2.
REQ-025 SHALL drive TRAP with pcwrite=1, pcsig=3, trap=1, all other strobes 0.
REQ-026 SHALL drive every output not listed for a state to 0.
REQ-027 SHALL compute pcen = pcwrite | (branch term & zero), combinationally, with zero-cycle latency.
REQ-028 SHALL increment retired by 1 on each edge that leaves MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP for FETCH; TRAP does not count.
REQ-029 SHALL let retired wrap modulo 2^CNT_W.
REQ-030 SHALL sample instr only in DECODE and MEMADR; instr changes in other states have no effect.

Reset
REQ-031 SHALL, while nrst=0, force cs=FETCH and retired=0.
REQ-032 SHALL, while nrst=0, force mem_req, instwr, pcwrite, pcen, memwrite, regwrite and trap to 0, and all other outputs to their FETCH values.
REQ-033 SHALL abort any in-flight instruction on a reset mid-instruction, including during a mem_rdy stall, with no write strobe on the following edge.
REQ-034 SHALL begin FETCH on the first rising edge after nrst deasserts.

Structure
REQ-035 SHALL place the state codes, opcode codes, pcsig/alusrcb/aluop encodings and default widths in shared package mc_pkg.
REQ-036 SHALL contain one sub-module, mc_decode: a combinational Moore output decoder from state and mem_rdy to control outputs; the next-state logic and retire counter stay in the top module.

Verification
REQ-037 SHALL cover R-type: instr=0x0123, mem_rdy=1 -> cs sequence 0,1,6,7,0; regwrite=1 and regdst=1 only in ALUWB; retired 0->1.
REQ-038 SHALL cover LW with wait states: instr=0x1xxx, mem_rdy low 3 cycles in MEMRD -> cs holds 3 for 4 cycles; load=1 in MEMWB; 5 states plus stalls.
REQ-039 SHALL cover BEQ: zero=1 -> pcen=1 in BRANCH; zero=0 -> pcen=0; retired increments in both cases.
REQ-040 SHALL cover an illegal opcode: instr=0xF000 -> cs 0,1,12,0; trap=1 and pcsig=3 for one cycle; retired unchanged.
REQ-041 SHALL cover reset during a MEMWR stall: nrst=0 -> cs=0 and memwrite=0 immediately (asynchronous); retired=0.
REQ-042 SHALL cover wrap: CNT_W=4, 16 ADDI instructions -> retired returns to 0.
